// File: rtl/key_led_ctrl.sv
// key_led_ctrl: key-pulse driven 4-mode LED display (OFF, ALL_ON, BLINK, FLOW) paced by a tick timer
//   sclk     : system clock, rising edge
//   s_rst    : asynchronous active-high reset
//   key_flag : one-cycle press pulse, advances the mode
//   pause    : level, freezes the tick timer and therefore the pattern
//   mode     : current mode (0=OFF, 1=ALL_ON, 2=BLINK, 3=FLOW)
//   led      : registered LED drive, active high
module key_led_ctrl #(
    parameter int CNT_TICK = 25_000_000,
    parameter int LED_W    = 4
) (
    input  logic             sclk,
    input  logic             s_rst,
    input  logic             key_flag,
    input  logic             pause,
    output logic [1:0]       mode,
    output logic [LED_W-1:0] led
);
    localparam int CW = (CNT_TICK > 1) ? $clog2(CNT_TICK) : 1;

    typedef enum logic [1:0] {OFF = 2'd0, ALL_ON = 2'd1, BLINK = 2'd2, FLOW = 2'd3} mode_t;

    mode_t            r_state, w_next;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [LED_W-1:0] r_led, w_led_nxt, w_entry;
    logic             w_tick;

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_led   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_led   <= w_led_nxt;
        end
    end

    // A key press restarts the timer and loads the entry pattern, discarding any coincident tick.
    // In BLINK the LED value itself is the blink phase.
    always_comb begin
        w_tick    = !pause && (r_cnt == CW'(CNT_TICK - 1));
        w_next    = key_flag ? mode_t'(r_state + 2'd1) : r_state;
        w_cnt_nxt = (key_flag || w_tick) ? '0 : pause ? r_cnt : r_cnt + CW'(1);
        w_entry   = (w_next == FLOW) ? LED_W'(1) : (w_next == OFF) ? '0 : '1;
        w_led_nxt = key_flag ? w_entry :
                    !w_tick ? r_led :
                    (r_state == BLINK) ? ~r_led :
                    (r_state == FLOW) ? {r_led[LED_W-2:0], r_led[LED_W-1]} : r_led;
    end

    assign mode = r_state;
    assign led  = r_led;
endmodule
